id_ex_stage: RTL

//  ID/EX pipeline register of the 5-stage LEGv8 core. Captures the decoded control bundle from the

---
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage LEGv8 core.
// It captures the decoded control bundle, the operands, the PC and the register indices,
// and presents them to EX one cycle later.
// It owns load-use hazard detection: it inserts one bubble and stalls PC and IF/ID.
// A branch flush from EX and an external hold (memory wait) are also honoured.
// Optional feature macro: ID_EX_PERF_EN enables the BubbleCnt/FlushCnt performance counters.
// When the macro is undefined, both counter outputs are tied to zero.
//
// Handshake: there is no valid/ready pair here.
// Stall is a combinational request that PC and IF/ID hold their contents this cycle.
// Hold freezes this register.
// Flush overrides both.

`ifndef BCOND_OP_NONE
`define BCOND_OP_NONE 3'd0
`endif

module id_ex_stage #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Hold,
    input  logic              Flush,
    input  logic              ID_RegWrite,
    input  logic              ID_WRegLoc,
    input  logic              ID_ALUSrc,
    input  logic              ID_SregUp,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic [1:0]        ID_ALUOp,
    input  logic [2:0]        ID_BranchOp,
    input  logic [1:0]        ID_MemtoReg,
    input  logic [AWIDTH-1:0] ID_PC,
    input  logic [DWIDTH-1:0] ID_RData1,
    input  logic [DWIDTH-1:0] ID_RData2,
    input  logic [DWIDTH-1:0] ID_Imm,
    input  logic [4:0]        ID_Rn,
    input  logic [4:0]        ID_Rm,
    input  logic [4:0]        ID_Rd,
    input  logic [10:0]       ID_Opcode,
    output logic              EX_RegWrite,
    output logic              EX_WRegLoc,
    output logic              EX_ALUSrc,
    output logic              EX_SregUp,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic [1:0]        EX_ALUOp,
    output logic [2:0]        EX_BranchOp,
    output logic [1:0]        EX_MemtoReg,
    output logic [AWIDTH-1:0] EX_PC,
    output logic [DWIDTH-1:0] EX_RData1,
    output logic [DWIDTH-1:0] EX_RData2,
    output logic [DWIDTH-1:0] EX_Imm,
    output logic [4:0]        EX_Rn,
    output logic [4:0]        EX_Rm,
    output logic [4:0]        EX_Rd,
    output logic [10:0]       EX_Opcode,
    output logic              Stall,
    output logic [31:0]       BubbleCnt,
    output logic [31:0]       FlushCnt
);

    // Control bundle: 6 single bits, ALUOp(2), BranchOp(3), MemtoReg(2).
    localparam int CTL_W = 13;
    // Data bundle: PC, three data words, three 5-bit indices, 11-bit opcode.
    localparam int DAT_W = AWIDTH + 3 * DWIDTH + 15 + 11;
    // A bubble has no architectural effect: no writes, no memory access, no branch.
    localparam logic [CTL_W-1:0] CTL_BUBBLE = {6'b0, 2'b0, `BCOND_OP_NONE, 2'b0};

    logic [CTL_W-1:0] ctl_in, ctl_d, ctl_q;
    logic [DAT_W-1:0] dat_in, dat_d, dat_q;
    logic             haz;

    assign ctl_in = {ID_RegWrite, ID_WRegLoc, ID_ALUSrc, ID_SregUp, ID_MemRead, ID_MemWrite,
                     ID_ALUOp, ID_BranchOp, ID_MemtoReg};
    assign dat_in = {ID_PC, ID_RData1, ID_RData2, ID_Imm, ID_Rn, ID_Rm, ID_Rd, ID_Opcode};

    assign {EX_RegWrite, EX_WRegLoc, EX_ALUSrc, EX_SregUp, EX_MemRead, EX_MemWrite,
            EX_ALUOp, EX_BranchOp, EX_MemtoReg} = ctl_q;
    assign {EX_PC, EX_RData1, EX_RData2, EX_Imm, EX_Rn, EX_Rm, EX_Rd, EX_Opcode} = dat_q;

    // A load in EX whose destination feeds the decode instruction.
    // XZR (register 31) is never a real producer, so it never triggers a hazard.
    assign haz   = EX_MemRead & (EX_Rd != 5'd31) & ((EX_Rd == ID_Rn) | (EX_Rd == ID_Rm));
    // A squashed instruction need not be stalled.
    // Reset also masks the stall request.
    assign Stall = haz & ~Flush & ~rst;

    // Next-state selection: Flush > Hold > hazard bubble > normal capture.
    always_comb begin
        ctl_d = ctl_q;
        dat_d = dat_q;
        if (Flush) begin
            ctl_d = CTL_BUBBLE;
            dat_d = dat_in;
        end else if (Hold) begin
            ctl_d = ctl_q;
            dat_d = dat_q;
        end else if (haz) begin
            ctl_d = CTL_BUBBLE;
            dat_d = dat_in;
        end else begin
            ctl_d = ctl_in;
            dat_d = dat_in;
        end
    end

    // Pipeline register with synchronous reset to the bubble state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q <= CTL_BUBBLE;
            dat_q <= '0;
        end else begin
            ctl_q <= ctl_d;
            dat_q <= dat_d;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        bubble_edge;

    // A bubble is counted only when the hazard is the reason the controls are cleared.
    assign bubble_edge  = haz & ~Flush & ~Hold;
    assign bubble_cnt_d = bubble_cnt_q + {31'd0, bubble_edge};
    assign flush_cnt_d  = flush_cnt_q + {31'd0, Flush};

    // Free-running performance counters that wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign BubbleCnt = bubble_cnt_q;
    assign FlushCnt  = flush_cnt_q;
`else
    assign BubbleCnt = '0;
    assign FlushCnt  = '0;
`endif

endmodule
